field_cfg_rom: RTL and testbench
================================

# field_cfg_rom

Read-only pattern store that supplies the initial Game-of-Life field contents, one cell per lookup. The field controller addresses it by cell coordinates while loading the field memory at start-up or restart. The stored pattern is fixed at elaboration time by `CONFIG_ID`. The registered output is returned one clock later.

## Interface

- `FIELD_W`, default 4: field width in cells; must be ≥ 2.
- `FIELD_H`, default 3: field height in cells; must be ≥ 2.
- `CONFIG_ID`, default 0: selects the initial pattern (see Operation).
- Local parameters:
  - `X_ADR_SIZE = $clog2(FIELD_W)`
  - `Y_ADR_SIZE = $clog2(FIELD_H)`
- `i_clk`, input, 1: single clock; all state changes on the rising edge.
- `i_rst_n`, input, 1: reset, synchronous and active-low.
- `i_cell_x_adr`, input, `X_ADR_SIZE`: cell column, 0 is leftmost.
- `i_cell_y_adr`, input, `Y_ADR_SIZE`: cell row, 0 is top.
- `o_cell_state`, output, 1: 1 means the cell is alive; registered.

## Operation

- Alive rule for in-range `(x, y)` depends on `CONFIG_ID`:
  - 0, EMPTY: all cells dead.
  - 1, GLIDER: alive at (1,0), (2,1), (0,2), (1,2), (2,2).
  - 2, BLINKER: alive at y = `FIELD_H/2`, x ∈ {`FIELD_W/2`−1, `FIELD_W/2`, `FIELD_W/2`+1}.
  - 3, FULL: all cells alive.
  - Any other value, HASH: alive iff (x + 2·y + `CONFIG_ID`) mod 3 == 0.
    - Evaluate in 32-bit unsigned arithmetic.
    - `CONFIG_ID` mod 3 is an elaboration-time constant.
- Pattern cells outside the field are clipped (dropped); no error is raised.
- Out-of-range addresses (x ≥ `FIELD_W` or y ≥ `FIELD_H`) read as 0, unless the wrap feature is enabled.
- Pure lookup: there is no write path and no internal state other than the output register.

## Timing

- On reset (`i_rst_n` = 0 at a rising edge), `o_cell_state` becomes 0.
- Otherwise, `o_cell_state` at edge N+1 equals the pattern value of the address presented before edge N+1.
  - Latency is 1 cycle, throughput is 1 lookup per cycle, and there is no handshake.
- The address may change every cycle; back-to-back reads are independent.
- Reset asserted mid-scan clears the output on that edge.
- The first lookup after reset release returns its value one cycle later.

## Configuration

- Macro `FIELD_CFG_ROM_WRAP_EN`.
- Defined: out-of-range coordinates wrap toroidally, matching the torus field topology.
  - Effective x = x − `FIELD_W` when x ≥ `FIELD_W`; likewise for y with `FIELD_H`.
  - A single subtraction suffices because 2^`X_ADR_SIZE` < 2·`FIELD_W`.
- Undefined: out-of-range coordinates read as 0.

## Structure

- Package `field_cfg_pkg`:
  - Config ID constants `CFG_EMPTY = 0`, `CFG_GLIDER = 1`, `CFG_BLINKER = 2`, `CFG_FULL = 3`.
  - Function `cfg_cell_alive(cfg_id, x, y, w, h)` implementing the pattern rules, so the field controller and the bench share one golden model.
- Optional sub-module `field_cfg_pattern`: combinational `(x, y) → alive`. The top level adds range check/wrap plus the output register.

## Test plan

- Reset: hold `i_rst_n` = 0 for 2 cycles with address (2,0) and `CONFIG_ID` = 1000 → `o_cell_state` = 0.
- 4×3 field, `CONFIG_ID` = 1000: scan rows y = 0..2, x = 0..3, sampling one cycle after each address.
  - Required rows: `0010`, `1001`, `0100`.
- 4×3 field, `CONFIG_ID` = 1 (glider): rows `0100`, `0010`, `1110`.
- 5×3 field, `CONFIG_ID` = 2 (blinker): rows `00000`, `01110`, `00000`. Same field, `CONFIG_ID` = 0 → all 0; `CONFIG_ID` = 3 → all 1.
- 3×3 field, `CONFIG_ID` = 3, address (3,0):
  - Without macro → 0.
  - With `FIELD_CFG_ROM_WRAP_EN` → value of (0,0) = 1.
- Back-to-back: change the address every cycle on the 4×3 HASH field → every output matches the model with exactly 1-cycle lag. Reset mid-scan → 0 on that edge.

Source files
------------

// File: rtl/field_cfg_pkg.sv
// Pattern constants and golden cell-alive function shared by the
// initial-field ROM and its users.
package field_cfg_pkg;

  localparam int unsigned CFG_EMPTY   = 0;
  localparam int unsigned CFG_GLIDER  = 1;
  localparam int unsigned CFG_BLINKER = 2;
  localparam int unsigned CFG_FULL    = 3;

  // Cells outside w x h are clipped to dead.
  function automatic logic cfg_cell_alive(
    input int unsigned cfg_id,
    input int unsigned x,
    input int unsigned y,
    input int unsigned w,
    input int unsigned h
  );
    logic alive;
    alive = 1'b0;
    if ((x < w) && (y < h)) begin
      case (cfg_id)
        CFG_EMPTY:   alive = 1'b0;
        CFG_GLIDER:  alive = ((x == 32'd1) && (y == 32'd0))
                          || ((x == 32'd2) && (y == 32'd1))
                          || ((y == 32'd2) && (x <= 32'd2));
        CFG_BLINKER: alive = (y == h / 32'd2)
                          && (x + 32'd1 >= w / 32'd2)
                          && (x <= w / 32'd2 + 32'd1);
        CFG_FULL:    alive = 1'b1;
        default:     alive = ((x + 32'd2 * y + cfg_id) % 32'd3)
                             == 32'd0;
      endcase
    end
    return alive;
  endfunction

endpackage

// File: rtl/field_cfg_pattern.sv
// Combinational (x, y) -> alive lookup for the elaboration-time
// pattern selected by CONFIG_ID.
module field_cfg_pattern
  import field_cfg_pkg::*;
#(
  parameter int unsigned FIELD_W    = 4,
  parameter int unsigned FIELD_H    = 3,
  parameter int unsigned CONFIG_ID  = 0,
  parameter int unsigned X_ADR_SIZE = $clog2(FIELD_W),
  parameter int unsigned Y_ADR_SIZE = $clog2(FIELD_H)
) (
  input  logic [X_ADR_SIZE-1:0] i_x,
  input  logic [Y_ADR_SIZE-1:0] i_y,
  output logic                  o_alive
);

  assign o_alive = cfg_cell_alive(CONFIG_ID,
                                  32'(i_x),
                                  32'(i_y),
                                  FIELD_W,
                                  FIELD_H);

endmodule

// File: rtl/field_cfg_rom.sv
// Initial Game-of-Life field ROM, one registered cell per lookup.
// Define FIELD_CFG_ROM_WRAP_EN to wrap out-of-range coordinates.
module field_cfg_rom
  import field_cfg_pkg::*;
#(
  parameter  int unsigned FIELD_W    = 4,
  parameter  int unsigned FIELD_H    = 3,
  parameter  int unsigned CONFIG_ID  = 0,
  localparam int unsigned X_ADR_SIZE = $clog2(FIELD_W),
  localparam int unsigned Y_ADR_SIZE = $clog2(FIELD_H)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [X_ADR_SIZE-1:0] i_cell_x_adr,
  input  logic [Y_ADR_SIZE-1:0] i_cell_y_adr,
  output logic                  o_cell_state
);

  logic [31:0]           x_ext;
  logic [31:0]           y_ext;
  logic                  x_oor;
  logic                  y_oor;
  logic [X_ADR_SIZE-1:0] x_eff;
  logic [Y_ADR_SIZE-1:0] y_eff;
  logic                  alive;
  logic                  cell_d;
  logic                  cell_q;

  assign x_ext = 32'(i_cell_x_adr);
  assign y_ext = 32'(i_cell_y_adr);
  assign x_oor = (x_ext >= FIELD_W);
  assign y_oor = (y_ext >= FIELD_H);

`ifdef FIELD_CFG_ROM_WRAP_EN
  // One subtraction is enough: 2^ADR_SIZE < 2*FIELD.
  assign x_eff = x_oor ? X_ADR_SIZE'(x_ext - FIELD_W) : i_cell_x_adr;
  assign y_eff = y_oor ? Y_ADR_SIZE'(y_ext - FIELD_H) : i_cell_y_adr;
  assign cell_d = alive;
`else
  assign x_eff  = i_cell_x_adr;
  assign y_eff  = i_cell_y_adr;
  assign cell_d = alive & ~x_oor & ~y_oor;
`endif

  field_cfg_pattern #(
    .FIELD_W    (FIELD_W),
    .FIELD_H    (FIELD_H),
    .CONFIG_ID  (CONFIG_ID),
    .X_ADR_SIZE (X_ADR_SIZE),
    .Y_ADR_SIZE (Y_ADR_SIZE)
  ) u_pattern (
    .i_x     (x_eff),
    .i_y     (y_eff),
    .o_alive (alive)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cell_q <= 1'b0;
    end else begin
      cell_q <= cell_d;
    end
  end

  assign o_cell_state = cell_q;

endmodule

// File: tb/tb_field_cfg_rom.sv
// Directed checks of field_cfg_rom patterns, clipping/wrap,
// latency and reset across several field sizes and configs.
module tb_field_cfg_rom;

  logic       clk;
  logic       rst_n;
  logic [1:0] x2;
  logic [2:0] x5;
  logic [1:0] ya;

  logic o_hash, o_glid, o_blk, o_emp, o_full, o_sq;

  int checks = 0;
  int errors = 0;

  logic [3:0] hash_rows [3] = '{4'b0010, 4'b1001, 4'b0100};
  logic [3:0] glid_rows [3] = '{4'b0100, 4'b0010, 4'b1110};
  logic [4:0] blk_rows  [3] = '{5'b00000, 5'b01110, 5'b00000};

  field_cfg_rom #(.FIELD_W(4), .FIELD_H(3), .CONFIG_ID(1000)) u_hash (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cell_x_adr(x2), .i_cell_y_adr(ya), .o_cell_state(o_hash));

  field_cfg_rom #(.FIELD_W(4), .FIELD_H(3), .CONFIG_ID(1)) u_glid (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cell_x_adr(x2), .i_cell_y_adr(ya), .o_cell_state(o_glid));

  field_cfg_rom #(.FIELD_W(5), .FIELD_H(3), .CONFIG_ID(2)) u_blk (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cell_x_adr(x5), .i_cell_y_adr(ya), .o_cell_state(o_blk));

  field_cfg_rom #(.FIELD_W(5), .FIELD_H(3), .CONFIG_ID(0)) u_emp (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cell_x_adr(x5), .i_cell_y_adr(ya), .o_cell_state(o_emp));

  field_cfg_rom #(.FIELD_W(5), .FIELD_H(3), .CONFIG_ID(3)) u_full (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cell_x_adr(x5), .i_cell_y_adr(ya), .o_cell_state(o_full));

  field_cfg_rom #(.FIELD_W(3), .FIELD_H(3), .CONFIG_ID(3)) u_sq (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cell_x_adr(x2), .i_cell_y_adr(ya), .o_cell_state(o_sq));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic wrap_exp;

  initial begin
`ifdef FIELD_CFG_ROM_WRAP_EN
    wrap_exp = 1'b1;
`else
    wrap_exp = 1'b0;
`endif
    rst_n = 1'b0;
    x2    = 2'd2;
    x5    = 3'd2;
    ya    = 2'd0;
    repeat (2) step();
    chk("rst_hash", o_hash, 1'b0);
    chk("rst_full", o_full, 1'b0);
    chk("rst_sq", o_sq, 1'b0);

    rst_n = 1'b1;
    step();
    chk("first_hash", o_hash, 1'b1);

    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 4; x++) begin
        x2 = 2'(x);
        ya = 2'(y);
        step();
        chk($sformatf("hash(%0d,%0d)", x, y), o_hash, hash_rows[y][3-x]);
        chk($sformatf("glid(%0d,%0d)", x, y), o_glid, glid_rows[y][3-x]);
      end
    end

    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 5; x++) begin
        x5 = 3'(x);
        ya = 2'(y);
        step();
        chk($sformatf("blk(%0d,%0d)", x, y), o_blk, blk_rows[y][4-x]);
        chk($sformatf("emp(%0d,%0d)", x, y), o_emp, 1'b0);
        chk($sformatf("full(%0d,%0d)", x, y), o_full, 1'b1);
      end
    end

    x2 = 2'd3;
    ya = 2'd0;
    step();
    chk("sq(3,0)", o_sq, wrap_exp);
    x2 = 2'd0;
    ya = 2'd3;
    step();
    chk("sq(0,3)", o_sq, wrap_exp);
    x2 = 2'd1;
    ya = 2'd1;
    step();
    chk("sq(1,1)", o_sq, 1'b1);

    for (int i = 0; i < 24; i++) begin
      int unsigned xr;
      int unsigned yr;
      xr = $urandom_range(0, 3);
      yr = $urandom_range(0, 2);
      x2 = 2'(xr);
      ya = 2'(yr);
      step();
      chk($sformatf("b2b%0d(%0d,%0d)", i, xr, yr), o_hash,
          ((xr + 2 * yr + 1000) % 3) == 0);
    end

    x2 = 2'd2;
    ya = 2'd0;
    step();
    chk("pre_mid_rst", o_hash, 1'b1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_hash", o_hash, 1'b0);
    chk("mid_rst_full", o_full, 1'b0);
    rst_n = 1'b1;
    step();
    chk("post_rst_hash", o_hash, 1'b1);
    chk("post_rst_full", o_full, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
